// File: rtl/dmem_lsu.sv
// Load/store unit: one memory op at a time over a req/gnt + rvalid data bus,
// with store lane alignment, load extraction/extension and a load timeout.
module dmem_lsu #(
   parameter int TIMEOUT_CYC = 16,
   parameter int CNT_W       = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        op_valid,
   input  logic        op_we,
   input  logic [1:0]  op_size,
   input  logic        op_signed,
   input  logic [31:0] adr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic [31:0] rd,
   output logic        rd_valid,
   output logic        st_done,
   output logic        misalign_err,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_adr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t             r_state, w_next;
   logic [CNT_W-1:0]   r_cnt, w_cnt;
   logic               r_busy, r_rd_valid, r_st_done, r_mis, r_bus_err;
   logic               r_mem_req, r_mem_we;
   logic [31:0]        r_rd, r_mem_adr, r_mem_wdata;
   logic [3:0]         r_mem_be;
   logic               r_we, r_signed;
   logic [1:0]         r_size, r_off;

   logic               w_accept, w_word, w_half, w_misalign;
   logic               w_rd_valid, w_st_done, w_mis, w_bus_err;
   logic [3:0]         w_be;
   logic [31:0]        w_wd, w_ld;
   logic [7:0]         w_byte;
   logic [15:0]        w_hw;

   // The cycle after a result the FSM is idle but busy is still high, so the
   // pipeline's held op must not be taken twice.
   assign w_accept   = (r_state == S_IDLE) && !r_busy && op_valid;
   assign w_word     = op_size[1];
   assign w_half     = (op_size == 2'b01);
   assign w_misalign = (w_half && adr[0]) || (w_word && (adr[1:0] != 2'b00));

   always_comb begin
      w_be = 4'b1111;
      w_wd = wdata;
      if (op_size == 2'b00) begin
         w_be = 4'b0001 << adr[1:0];
         w_wd = {4{wdata[7:0]}};
      end else if (w_half) begin
         w_be = adr[1] ? 4'b1100 : 4'b0011;
         w_wd = {2{wdata[15:0]}};
      end
   end

   assign w_byte = mem_rdata[{r_off, 3'b000} +: 8];
   assign w_hw   = mem_rdata[{r_off[1], 4'b0000} +: 16];

   always_comb begin
      case (r_size)
         2'b00:   w_ld = {{24{r_signed & w_byte[7]}}, w_byte};
         2'b01:   w_ld = {{16{r_signed & w_hw[15]}}, w_hw};
         default: w_ld = mem_rdata;
      endcase
   end

   always_comb begin
      w_next     = r_state;
      w_cnt      = r_cnt;
      w_rd_valid = 1'b0;
      w_st_done  = 1'b0;
      w_mis      = 1'b0;
      w_bus_err  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_misalign) w_mis  = 1'b1;
               else            w_next = S_REQ;
            end
         end
         S_REQ: begin
            if (mem_gnt) begin
               if (r_we) begin
                  w_next    = S_IDLE;
                  w_st_done = 1'b1;
               end else begin
                  w_next = S_WAIT;
                  w_cnt  = '0;
               end
            end
         end
         S_WAIT: begin
            // rvalid takes priority over the timeout in the same cycle
            if (mem_rvalid) begin
               w_rd_valid = 1'b1;
               w_next     = S_IDLE;
            end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
               w_bus_err = 1'b1;
               w_next    = S_IDLE;
            end else begin
               w_cnt = r_cnt + CNT_W'(1);
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_busy      <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_st_done   <= 1'b0;
         r_mis       <= 1'b0;
         r_bus_err   <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_rd        <= '0;
         r_mem_adr   <= '0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
         r_we        <= 1'b0;
         r_signed    <= 1'b0;
         r_size      <= '0;
         r_off       <= '0;
      end else begin
         r_state    <= w_next;
         r_cnt      <= w_cnt;
         r_rd_valid <= w_rd_valid;
         r_st_done  <= w_st_done;
         r_mis      <= w_mis;
         r_bus_err  <= w_bus_err;
         r_busy     <= (w_next != S_IDLE) || (r_state != S_IDLE);
         r_mem_req  <= (w_next == S_REQ);
         if (w_accept && !w_misalign) begin
            r_we        <= op_we;
            r_signed    <= op_signed;
            r_size      <= op_size;
            r_off       <= adr[1:0];
            r_mem_adr   <= {adr[31:2], 2'b00};
            r_mem_be    <= w_be;
            r_mem_wdata <= w_wd;
            r_mem_we    <= op_we;
         end else if (w_next != S_REQ) begin
            r_mem_we <= 1'b0;
         end
         if (w_rd_valid)     r_rd <= w_ld;
         else if (w_bus_err) r_rd <= '0;
      end
   end

   assign busy         = r_busy;
   assign rd           = r_rd;
   assign rd_valid     = r_rd_valid;
   assign st_done      = r_st_done;
   assign misalign_err = r_mis;
   assign bus_err      = r_bus_err;
   assign mem_req      = r_mem_req;
   assign mem_we       = r_mem_we;
   assign mem_adr      = r_mem_adr;
   assign mem_be       = r_mem_be;
   assign mem_wdata    = r_mem_wdata;

endmodule
